// File: rtl/deser_align.sv
// Comma-aligned serial-to-parallel deserializer.
// Shifts in one bit per clock (MSB first), finds the word boundary from a comma
// symbol, qualifies lock on repeated aligned commas and drops lock on repeated
// misaligned ones. Each emitted word carries the K/D flag sampled with its last bit.
module deser_align #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
    parameter int unsigned      LOCK_COUNT = 3,
    parameter int unsigned      ERR_MAX    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             k_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_dk,
    output logic             valid_out,
    output logic             locked,
    output logic [1:0]       state
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam int unsigned ComW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned ErrW = $clog2(ERR_MAX + 1);

    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
    localparam logic [ComW-1:0] ComMax  = ComW'(LOCK_COUNT);
    localparam logic [ErrW-1:0] ErrLim  = ErrW'(ERR_MAX);

    typedef enum logic [1:0] {
        StHunt  = 2'd0,
        StCheck = 2'd1,
        StSync  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    // Only WIDTH-1 history bits are stored; the incoming bit completes the window.
    logic [WIDTH-2:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ComW-1:0]  com_cnt_q, com_cnt_d, com_inc;
    logic [ErrW-1:0]  err_cnt_q, err_cnt_d, err_inc;
    logic [WIDTH-1:0] data_q;
    logic             dk_q;
    logic             valid_q;
    logic             match;
    logic             boundary;
    logic             emit;

    assign sr_d     = {sr_q, data_in};
    assign match    = (sr_d == COMMA);
    assign boundary = (bit_cnt_q == LastBit);
    // Counters saturate at their thresholds.
    assign com_inc  = (com_cnt_q == ComMax) ? com_cnt_q : com_cnt_q + ComW'(1);
    assign err_inc  = (err_cnt_q == ErrLim) ? err_cnt_q : err_cnt_q + ErrW'(1);

    // Alignment FSM: next state, counters and word-emit decision.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        com_cnt_d = com_cnt_q;
        err_cnt_d = err_cnt_q;
        emit      = 1'b0;
        unique case (state_q)
            StHunt: begin
                bit_cnt_d = '0;
                if (match) begin
                    emit      = 1'b1;
                    com_cnt_d = ComW'(1);
                    err_cnt_d = '0;
                    state_d   = (LOCK_COUNT == 1) ? StSync : StCheck;
                end
            end
            StCheck: begin
                bit_cnt_d = boundary ? '0 : bit_cnt_q + CntW'(1);
                if (boundary) begin
                    emit = 1'b1;
                    if (match) begin
                        com_cnt_d = com_inc;
                        if (com_inc == ComMax) begin
                            state_d = StSync;
                        end
                    end
                end else if (match) begin
                    // Misaligned comma: abandon this boundary, search afresh next edge.
                    state_d   = StHunt;
                    com_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            StSync: begin
                bit_cnt_d = boundary ? '0 : bit_cnt_q + CntW'(1);
                if (boundary) begin
                    emit = 1'b1;
                    if (match) begin
                        err_cnt_d = '0;
                    end
                end else if (match) begin
                    err_cnt_d = err_inc;
                    if (err_inc == ErrLim) begin
                        state_d   = StHunt;
                        bit_cnt_d = '0;
                        com_cnt_d = '0;
                        err_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d   = StHunt;
                bit_cnt_d = '0;
                com_cnt_d = '0;
                err_cnt_d = '0;
            end
        endcase
    end

    // State, shift register, counters and registered word outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StHunt;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            err_cnt_q <= '0;
            data_q    <= '0;
            dk_q      <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d[WIDTH-2:0];
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            err_cnt_q <= err_cnt_d;
            valid_q   <= emit;
            if (emit) begin
                data_q <= sr_d;
                dk_q   <= k_in;
            end
        end
    end

    assign data_out  = data_q;
    assign out_dk    = dk_q;
    assign valid_out = valid_q;
    assign locked    = (state_q == StSync);
    assign state     = state_q;

endmodule

// File: doc/deser_align.md
Name: deser_align

Overview:
- Parametrised successor to the fixed 8-bit serial-to-parallel deserializer.
- Converts a 1-bit-per-clock serial stream (MSB first) into WIDTH-bit words. Unlike the fixed-boundary predecessor, it finds the word boundary by searching for a comma (COM) symbol.
- Qualifies lock after repeated aligned commas and drops lock on repeated misaligned commas.
- Sits between the serial link receiver and the symbol decoder. Forwards the per-word K/D flag with each word.

Parameters:
- WIDTH, 8, word width in bits (>=4).
- COMMA, 8'hBC, comma pattern (WIDTH bits) used for alignment.
- LOCK_COUNT, 3, aligned commas (including the first hit) needed to enter SYNC (>=1).
- ERR_MAX, 2, misaligned commas in SYNC, without an intervening aligned comma, that force HUNT (>=1).

Ports:
- clk  input  1  single clock; all logic on posedge only.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial bit, MSB of each word first.
- k_in  input  1  K/D flag, sampled on the cycle the last bit of a word is taken.
- data_out  output  WIDTH  last completed aligned word.
- out_dk  output  1  K flag belonging to data_out.
- valid_out  output  1  one-cycle strobe: data_out/out_dk updated.
- locked  output  1  high while in SYNC.
- state  output  2  current state: 0=HUNT, 1=CHECK, 2=SYNC.

Behaviour:
- Reset (sync, active-high): values after the edge where reset is sampled high:
  - data_out=0, out_dk=0, valid_out=0, locked=0, state=HUNT.
  - shift register, bit_cnt, com_cnt and err_cnt all 0.
  - Reset mid-word discards any partial word. No valid_out while reset is high.
- Shifting, every edge:
  - sr_next = {sr[WIDTH-2:0], data_in}; sr <= sr_next.
  - match = (sr_next == COMMA).
  - boundary = (bit_cnt == WIDTH-1).
- Word output:
  - When a word is emitted at an edge: data_out <= sr_next, out_dk <= k_in, valid_out <= 1 for exactly one cycle.
  - Latency: the word appears the cycle after its last bit is sampled.
  - valid_out is never asserted in HUNT, except on the hit edge itself.
- bit_cnt:
  - Counts 0..WIDTH-1 in CHECK/SYNC and wraps to 0 on boundary.
  - Forced to 0 on a HUNT hit, so the next word boundary is exactly WIDTH edges later.
- HUNT:
  - match on any edge: emit COMMA word, bit_cnt<=0, com_cnt<=1.
  - Go to SYNC if LOCK_COUNT==1, else CHECK.
  - No match: stay in HUNT, no output.
- CHECK:
  - boundary: emit word.
    - If match: com_cnt++. Reaching LOCK_COUNT -> SYNC, locked<=1 on the same edge.
    - Non-comma boundary words are emitted; com_cnt is held.
  - match && !boundary (misaligned comma): go to HUNT, com_cnt<=0, no emit.
    - The misaligned comma is not reused as a hit. HUNT restarts searching from the next edge.
- SYNC:
  - boundary: emit word. If match, err_cnt<=0.
  - match && !boundary: err_cnt++.
    - err_cnt reaching ERR_MAX -> HUNT, locked<=0, counters cleared.
- Simultaneous events:
  - A boundary match takes priority as aligned; it is never misaligned.
  - reset overrides every transition.
- Width rules:
  - bit_cnt width = clog2(WIDTH).
  - com_cnt and err_cnt saturate at their thresholds; no wrap.

Test Plan (WIDTH=8, COMMA=8'hBC, LOCK_COUNT=3, ERR_MAX=2):
1. Reset held for 3 cycles mid-stream with random bits -> all outputs 0, state=0. Reset released then 10 random non-comma bits -> no valid_out.
2. 5 random bits then 10111100 -> valid_out pulse with data_out=8'hBC one cycle after the last bit; state=1; locked=0.
3. Continue with aligned BC, BC, 5C, FB -> locked=1 on the cycle after the 3rd BC. valid_out pulses every 8 cycles with data BC, BC, 5C, FB. out_dk follows k_in=1,1,0,1.
4. In CHECK, insert BC shifted by 3 bits -> no valid_out for it; state=0. The next aligned BC re-hits with a new boundary.
5. In SYNC, two misaligned BCs with no aligned BC between -> locked falls after the 2nd; state=0. Repeat as misaligned, aligned BC, misaligned -> stays locked.
6. WIDTH=10, COMMA=10'h17C: lock sequence as in scenario 3 -> valid_out every 10 cycles with correct 10-bit words.
